// File: rtl/debug_dump_tx.sv
// Debug dump transmit sequencer: streams PC, register file and (with DEBUG_DUMP_MEM_EN)
// data memory to the UART one byte at a time, least-significant byte first.
module debug_dump_tx #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_WIDTH_UART = 8,
    parameter int N_REGS          = 32,
    parameter int N_MEM           = 32
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_start,
    input  logic [DATA_WIDTH-1:0]      i_pc,
    output logic [4:0]                 o_reg_addr,
    input  logic [DATA_WIDTH-1:0]      i_reg_data,
    output logic [4:0]                 o_mem_addr,
    input  logic [DATA_WIDTH-1:0]      i_mem_data,
    output logic                       o_tx_signal,
    output logic [DATA_WIDTH_UART-1:0] o_tx_byte,
    input  logic                       i_tx_done,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int BYTES  = DATA_WIDTH / DATA_WIDTH_UART;
    localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES - 1);
    localparam logic [4:0]        LAST_REG  = 5'(N_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LOAD, S_SEND, S_WAIT, S_FINISH
    } state_t;

    typedef enum logic [1:0] {
        SEC_PC, SEC_REG, SEC_MEM
    } sec_t;

    state_t                     state_q;
    sec_t                       sec_q;
    logic [DATA_WIDTH-1:0]      word_q;
    logic [BIDX_W-1:0]          byte_idx_q;
    logic [4:0]                 word_idx_q;
    logic [4:0]                 reg_addr_q;
    logic                       tx_signal_q;
    logic [DATA_WIDTH_UART-1:0] tx_byte_q;
    logic                       busy_q;
    logic                       done_q;
    logic [DATA_WIDTH-1:0]      load_data;

    function automatic logic [DATA_WIDTH_UART-1:0] byte_sel(
        input logic [DATA_WIDTH-1:0] w,
        input logic [BIDX_W-1:0]     idx
    );
        logic [DATA_WIDTH-1:0] sh;
        sh = w >> (int'(idx) * DATA_WIDTH_UART);
        return sh[DATA_WIDTH_UART-1:0];
    endfunction

`ifdef DEBUG_DUMP_MEM_EN
    localparam logic [4:0] LAST_MEM = 5'(N_MEM - 1);
    logic [4:0] mem_addr_q;

    always_comb begin
        load_data = i_reg_data;
        if (sec_q == SEC_MEM) load_data = i_mem_data;
    end

    assign o_mem_addr = mem_addr_q;
`else
    logic unused_mem;

    always_comb begin
        load_data = i_reg_data;
    end

    assign unused_mem = ^i_mem_data;
    assign o_mem_addr = '0;
`endif

    // Read addresses are registered on the edge entering ADDR so the memories have
    // the whole ADDR cycle to respond before LOAD captures the word.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            sec_q       <= SEC_PC;
            word_q      <= '0;
            byte_idx_q  <= '0;
            word_idx_q  <= '0;
            reg_addr_q  <= '0;
`ifdef DEBUG_DUMP_MEM_EN
            mem_addr_q  <= '0;
`endif
            tx_signal_q <= 1'b0;
            tx_byte_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            tx_signal_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        word_q      <= i_pc;
                        sec_q       <= SEC_PC;
                        word_idx_q  <= '0;
                        byte_idx_q  <= '0;
                        tx_byte_q   <= i_pc[DATA_WIDTH_UART-1:0];
                        tx_signal_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_SEND;
                    end
                end
                S_ADDR: state_q <= S_LOAD;
                S_LOAD: begin
                    word_q      <= load_data;
                    byte_idx_q  <= '0;
                    tx_byte_q   <= load_data[DATA_WIDTH_UART-1:0];
                    tx_signal_q <= 1'b1;
                    state_q     <= S_SEND;
                end
                S_SEND: state_q <= S_WAIT;
                S_WAIT: begin
                    if (i_tx_done) begin
                        if (byte_idx_q != LAST_BYTE) begin
                            byte_idx_q  <= byte_idx_q + 1'b1;
                            tx_byte_q   <= byte_sel(word_q, byte_idx_q + 1'b1);
                            tx_signal_q <= 1'b1;
                            state_q     <= S_SEND;
                        end else begin
                            case (sec_q)
                                SEC_PC: begin
                                    sec_q      <= SEC_REG;
                                    word_idx_q <= '0;
                                    reg_addr_q <= '0;
                                    state_q    <= S_ADDR;
                                end
                                SEC_REG: begin
                                    if (word_idx_q != LAST_REG) begin
                                        word_idx_q <= word_idx_q + 5'd1;
                                        reg_addr_q <= word_idx_q + 5'd1;
                                        state_q    <= S_ADDR;
                                    end else begin
`ifdef DEBUG_DUMP_MEM_EN
                                        sec_q      <= SEC_MEM;
                                        word_idx_q <= '0;
                                        mem_addr_q <= '0;
                                        state_q    <= S_ADDR;
`else
                                        busy_q     <= 1'b0;
                                        done_q     <= 1'b1;
                                        state_q    <= S_FINISH;
`endif
                                    end
                                end
`ifdef DEBUG_DUMP_MEM_EN
                                SEC_MEM: begin
                                    if (word_idx_q != LAST_MEM) begin
                                        word_idx_q <= word_idx_q + 5'd1;
                                        mem_addr_q <= word_idx_q + 5'd1;
                                        state_q    <= S_ADDR;
                                    end else begin
                                        busy_q     <= 1'b0;
                                        done_q     <= 1'b1;
                                        state_q    <= S_FINISH;
                                    end
                                end
`endif
                                default: begin
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                    state_q <= S_FINISH;
                                end
                            endcase
                        end
                    end
                end
                S_FINISH: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign o_reg_addr  = reg_addr_q;
    assign o_tx_signal = tx_signal_q;
    assign o_tx_byte   = tx_byte_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_debug_dump_tx.sv
// Scoreboard bench for debug_dump_tx: expected byte streams are built from the memory
// images when a start is accepted and popped by a monitor on every o_tx_signal.
module tb_debug_dump_tx;

    localparam int NREG = 32;
    localparam int NMEM = 32;
`ifdef DEBUG_DUMP_MEM_EN
    localparam int NWORDS = 1 + NREG + NMEM;
`else
    localparam int NWORDS = 1 + NREG;
`endif

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [31:0] i_pc;
    logic [4:0]  o_reg_addr;
    logic [31:0] i_reg_data;
    logic [4:0]  o_mem_addr;
    logic [31:0] i_mem_data;
    logic        o_tx_signal;
    logic [7:0]  o_tx_byte;
    logic        i_tx_done;
    logic        o_busy;
    logic        o_done;
    logic        uart_done;
    logic        spur_done;

    logic [31:0] regs_m [NREG];
    logic [31:0] mem_m  [NMEM];
    logic [7:0]  exp_q [$];
    logic [7:0]  rx [$];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   npulses = 0;
    int   nacked = 0;
    int   ndone = 0;
    int   acc_cyc = 0;
    int   start_cyc = 0;
    bit   mbusy = 1'b0;
    bit   waiting = 1'b0;
    bit   spur_send_en = 1'b0;
    int   fixed_delay = 10;
    logic [7:0] held_byte = '0;

    assign i_tx_done = uart_done | spur_done;

    debug_dump_tx #(
        .DATA_WIDTH(32),
        .DATA_WIDTH_UART(8),
        .N_REGS(NREG),
        .N_MEM(NMEM)
    ) dut (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .i_start(i_start),
        .i_pc(i_pc),
        .o_reg_addr(o_reg_addr),
        .i_reg_data(i_reg_data),
        .o_mem_addr(o_mem_addr),
        .i_mem_data(i_mem_data),
        .o_tx_signal(o_tx_signal),
        .o_tx_byte(o_tx_byte),
        .i_tx_done(i_tx_done),
        .o_busy(o_busy),
        .o_done(o_done)
    );

    initial forever #5 i_clock = ~i_clock;

    // Synchronous read ports: data follows the address one cycle later.
    always @(posedge i_clock) begin
        i_reg_data <= regs_m[o_reg_addr];
        i_mem_data <= mem_m[o_mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_expected();
        logic [31:0] w;
        for (int k = 0; k < NWORDS; k++) begin
            if (k == 0)          w = i_pc;
            else if (k <= NREG)  w = regs_m[k-1];
            else                 w = mem_m[k-1-NREG];
            for (int b = 0; b < 4; b++)
                exp_q.push_back(8'((w >> (8 * b)) & 32'hFF));
        end
    endfunction

    // Monitor / scoreboard: inputs change on negedges, so sampling 1 unit later sees
    // exactly what the next rising edge will see.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge i_clock);
            #1;
            cyc++;
            if (i_reset) begin
                exp_q.delete();
                mbusy   = 1'b0;
                waiting = 1'b0;
            end else begin
                if (i_start && !mbusy) begin
                    push_expected();
                    rx.delete();
                    mbusy     = 1'b1;
                    start_cyc = cyc;
                    npulses   = 0;
                    nacked    = 0;
                end
                if (o_tx_signal) begin
                    chk("no_double_pulse", 32'(waiting), 32'd0);
                    chk("busy_at_pulse", 32'(o_busy), 32'd1);
                    if (!mbusy || exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse: got byte %h with nothing expected (cycle %0d)", o_tx_byte, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_byte", 32'(o_tx_byte), 32'(e));
                        if (npulses == 0)
                            chk("start_latency", 32'(cyc - start_cyc), 32'd1);
                        else
                            chk("done_to_pulse_latency", 32'(cyc - acc_cyc), (npulses % 4 == 0) ? 32'd3 : 32'd1);
                    end
`ifndef DEBUG_DUMP_MEM_EN
                    chk("mem_addr_tied", 32'(o_mem_addr), 32'd0);
`endif
                    rx.push_back(o_tx_byte);
                    held_byte = o_tx_byte;
                    npulses++;
                    waiting = 1'b1;
                end else if (waiting) begin
                    chk("byte_stable", 32'(o_tx_byte), 32'(held_byte));
                    if (i_tx_done) begin
                        waiting = 1'b0;
                        nacked++;
                        acc_cyc = cyc;
                    end
                end
                if (o_done) begin
                    chk("done_while_dumping", 32'(mbusy), 32'd1);
                    chk("done_latency", 32'(cyc - acc_cyc), 32'd1);
                    chk("byte_count", 32'(nacked), 32'(NWORDS * 4));
                    chk("queue_empty", 32'(exp_q.size()), 32'd0);
                    chk("busy_low_at_done", 32'(o_busy), 32'd0);
                    mbusy = 1'b0;
                    ndone++;
                end
            end
        end
    end

    // UART model: acknowledges each pulse after a delay, optionally with a bogus
    // done in the SEND cycle itself.
    initial begin
        int d;
        uart_done = 1'b0;
        forever begin
            @(negedge i_clock);
            uart_done = 1'b0;
            if (o_tx_signal && !i_reset) begin
                d = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 8));
                if (spur_send_en && $urandom_range(0, 3) == 0) uart_done = 1'b1;
                repeat (d) begin
                    @(negedge i_clock);
                    uart_done = 1'b0;
                end
                uart_done = 1'b1;
            end
        end
    end

    task automatic pulse_start();
        @(negedge i_clock);
        i_start = 1'b1;
        @(negedge i_clock);
        i_start = 1'b0;
    endtask

    task automatic wait_pulses(input int n, input int limit);
        int k = 0;
        while (npulses < n && k < limit) begin
            @(negedge i_clock);
            k++;
        end
        if (npulses < n) begin
            checks++;
            errors++;
            $display("FAIL wait_pulses: got %0d pulses required %0d", npulses, n);
        end
    endtask

    task automatic wait_done(input int prev, input int limit);
        int k = 0;
        while (ndone == prev && k < limit) begin
            @(negedge i_clock);
            k++;
        end
        repeat (5) @(negedge i_clock);
        chk("one_done_pulse", 32'(ndone - prev), 32'd1);
    endtask

    task automatic randomize_images();
        i_pc = $urandom();
        for (int k = 0; k < NREG; k++) regs_m[k] = $urandom();
        for (int k = 0; k < NMEM; k++) mem_m[k] = $urandom();
    endtask

    initial begin
        int prev;
        int sp;
        logic [31:0] w;
        i_reset   = 1'b1;
        i_start   = 1'b0;
        spur_done = 1'b0;
        i_pc      = 32'h0000_0028;
        for (int k = 0; k < NREG; k++) regs_m[k] = 32'h100 + 32'(k);
        for (int k = 0; k < NMEM; k++) mem_m[k] = 32'hA000 + 32'(k);

        repeat (3) @(negedge i_clock);
        chk("rst_tx_signal", 32'(o_tx_signal), 32'd0);
        chk("rst_tx_byte", 32'(o_tx_byte), 32'd0);
        chk("rst_reg_addr", 32'(o_reg_addr), 32'd0);
        chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        i_reset = 1'b0;

        // Spurious done while idle.
        repeat (2) @(negedge i_clock);
        spur_done = 1'b1;
        @(negedge i_clock);
        spur_done = 1'b0;
        repeat (3) @(negedge i_clock);
        chk("idle_spur_signal", 32'(o_tx_signal), 32'd0);
        chk("idle_spur_busy", 32'(o_busy), 32'd0);

        // Dump A: fixed images, UART answers 10 cycles after each pulse.
        prev = ndone;
        pulse_start();
        wait_done(prev, 20000);
        chk("rx_len", 32'(rx.size()), 32'(NWORDS * 4));
        if (rx.size() >= NWORDS * 4) begin
            chk("pc_byte0", 32'(rx[0]), 32'h28);
            chk("pc_byte1", 32'(rx[1]), 32'h00);
            chk("pc_byte2", 32'(rx[2]), 32'h00);
            chk("pc_byte3", 32'(rx[3]), 32'h00);
            w = {rx[131], rx[130], rx[129], rx[128]};
            chk("reg31_word", w, 32'h0000_011F);
`ifdef DEBUG_DUMP_MEM_EN
            w = {rx[259], rx[258], rx[257], rx[256]};
            chk("mem31_word", w, 32'h0000_A01F);
`endif
        end

        // Dump B: random images and UART timing, bogus done in SEND, restart at byte 50.
        randomize_images();
        fixed_delay  = 0;
        spur_send_en = 1'b1;
        prev = ndone;
        pulse_start();
        wait_pulses(50, 5000);
        pulse_start();
        wait_done(prev, 20000);

        // Dump C: a start right after done begins a fresh stream at the PC.
        randomize_images();
        prev = ndone;
        pulse_start();
        wait_done(prev, 20000);

        // Dump D: reset while waiting on byte 100.
        randomize_images();
        fixed_delay  = 10;
        spur_send_en = 1'b0;
        pulse_start();
        wait_pulses(101, 8000);
        repeat (3) @(negedge i_clock);
        #3;
        i_reset = 1'b1;
        #1;
        chk("abort_tx_signal", 32'(o_tx_signal), 32'd0);
        chk("abort_tx_byte", 32'(o_tx_byte), 32'd0);
        chk("abort_reg_addr", 32'(o_reg_addr), 32'd0);
        chk("abort_mem_addr", 32'(o_mem_addr), 32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        repeat (2) @(negedge i_clock);
        i_reset = 1'b0;
        sp = 0;
        repeat (40) begin
            @(negedge i_clock);
            if (o_tx_signal) sp++;
        end
        chk("no_pulse_after_reset", 32'(sp), 32'd0);

        // Dump E: normal operation after the abort.
        randomize_images();
        fixed_delay = 0;
        prev = ndone;
        pulse_start();
        wait_done(prev, 20000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
